// File: rtl/zeroriscy_multdiv_iter_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
// Optional feature macro: ZERORISCY_MULT_EARLY_EXIT_EN (multiply early exit).
package zeroriscy_multdiv_iter_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 5;

  // Iteration counter load value: 32 CALC cycles (31 down to 0)
  localparam logic [CNT_W-1:0] MD_CNT_LOAD = 5'd31;

  typedef enum logic [1:0] {
    MD_IDLE   = 2'd0,
    MD_CALC   = 2'd1,
    MD_FINISH = 2'd2
  } md_fsm_e;

  localparam logic [1:0] MD_OP_MULL = 2'd0;
  localparam logic [1:0] MD_OP_MULH = 2'd1;
  localparam logic [1:0] MD_OP_DIV  = 2'd2;
  localparam logic [1:0] MD_OP_REM  = 2'd3;

  // Two's-complement magnitude; 0x80000000 maps to itself as an unsigned value
  function automatic logic [DATA_W-1:0] md_magnitude(input logic [DATA_W-1:0] val,
                                                     input logic              is_neg);
    return is_neg ? (~val + 32'd1) : val;
  endfunction

endpackage

// File: rtl/zeroriscy_md_addsub.sv
// 33-bit add/subtract with carry-out, shared by shift-add multiply and
// restoring divide. For subtraction a carry-out of 1 means "no borrow".
module zeroriscy_md_addsub (
  input  logic [32:0] op_a,
  input  logic [32:0] op_b,
  input  logic        sub,
  output logic [32:0] sum,
  output logic        carry
);

  logic [33:0] res;

  // Single adder; subtraction is a + ~b + 1
  always_comb begin
    res = {1'b0, op_a} + {1'b0, (sub ? ~op_b : op_b)} + {33'd0, sub};
  end

  assign sum   = res[32:0];
  assign carry = res[33];

endmodule

// File: rtl/zeroriscy_multdiv_iter.sv
// Area-optimised iterative RV32M multiply/divide unit.
// Radix-2 shift-add multiply and restoring divide share one 33-bit adder.
// Fixed latency 34 cycles (launch, 32 CALC cycles, FINISH).
// Optional macro ZERORISCY_MULT_EARLY_EXIT_EN: multiply stops once the
// remaining multiplier is zero (divide unaffected).
module zeroriscy_multdiv_iter
  import zeroriscy_multdiv_iter_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mult_en_i,
  input  logic        div_en_i,
  input  logic [1:0]  operator_i,
  input  logic [1:0]  signed_mode_i,
  input  logic [31:0] op_a_i,
  input  logic [31:0] op_b_i,
  output logic        ready_o,
  output logic [31:0] multdiv_result_o
);

  md_fsm_e           state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              load_op, step_en, load_res;
  logic              req;

  // Operation context captured at launch
  logic              is_div_q;
  logic [1:0]        op_q;
  logic              sign_a_q, sign_b_q, b_zero_q;
  logic [31:0]       addend_q;

  // acc_q[64:32]: product high / partial remainder; acc_q[31:0]: multiplier / quotient
  logic [64:0]       acc_q, acc_step;
  logic [63:0]       acc_final;

  logic              sign_a, sign_b;
  logic [31:0]       a_mag, b_mag;

  logic [32:0]       as_a, as_b, as_sum;
  logic              as_carry;
  logic [32:0]       div_shift, div_rem;
  logic [33:0]       mul_hi;
  logic              calc_done;

`ifdef ZERORISCY_MULT_EARLY_EXIT_EN
  logic [31:0]       mplier_q;
`endif

  assign req    = mult_en_i | div_en_i;
  assign sign_a = signed_mode_i[0] & op_a_i[31];
  assign sign_b = signed_mode_i[1] & op_b_i[31];
  assign a_mag  = md_magnitude(op_a_i, sign_a);
  assign b_mag  = md_magnitude(op_b_i, sign_b);

  // Sign fix-up and result selection from the aligned accumulator
  function automatic logic [31:0] md_fixup(input logic [63:0] acc,
                                           input logic        is_div,
                                           input logic [1:0]  op,
                                           input logic        sa,
                                           input logic        sb,
                                           input logic        b_zero);
    logic [63:0] prod;
    logic [31:0] quo, rem;
    prod = (sa ^ sb) ? (~acc + 64'd1) : acc;
    quo  = acc[31:0];
    rem  = acc[63:32];
    if (!is_div) begin
      return (op == MD_OP_MULH) ? prod[63:32] : prod[31:0];
    end
    if (op == MD_OP_REM) begin
      return sa ? (~rem + 32'd1) : rem;
    end
    return ((sa ^ sb) && !b_zero) ? (~quo + 32'd1) : quo;
  endfunction

  zeroriscy_md_addsub u_addsub (
    .op_a  (as_a),
    .op_b  (as_b),
    .sub   (is_div_q),
    .sum   (as_sum),
    .carry (as_carry)
  );

  // One iteration of the shared datapath: trial subtract or conditional add
  always_comb begin
    div_shift = {acc_q[63:32], acc_q[31]};
    as_a      = is_div_q ? div_shift : acc_q[64:32];
    as_b      = {1'b0, addend_q};
    div_rem   = as_carry ? as_sum : div_shift;
    mul_hi    = acc_q[0] ? {as_carry, as_sum} : {1'b0, acc_q[64:32]};
    if (is_div_q) begin
      acc_step = {div_rem, acc_q[30:0], as_carry};
    end else begin
      acc_step = {mul_hi, acc_q[31:1]};
    end
  end

  // Completion test and final alignment of the product
  always_comb begin
`ifdef ZERORISCY_MULT_EARLY_EXIT_EN
    calc_done = (cnt_q == '0) || (!is_div_q && ((mplier_q >> 1) == 32'd0));
    acc_final = is_div_q ? acc_step[63:0] : 64'(acc_step >> cnt_q);
`else
    calc_done = (cnt_q == '0);
    acc_final = acc_step[63:0];
`endif
  end

  // Next-state and control decode
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    load_op  = 1'b0;
    step_en  = 1'b0;
    load_res = 1'b0;
    case (state_q)
      MD_IDLE: begin
        if (req) begin
          state_d = MD_CALC;
          cnt_d   = MD_CNT_LOAD;
          load_op = 1'b1;
        end
      end
      MD_CALC: begin
        if (!req) begin
          state_d = MD_IDLE;
        end else begin
          step_en = 1'b1;
          cnt_d   = cnt_q - 5'd1;
          if (calc_done) begin
            state_d  = MD_FINISH;
            cnt_d    = '0;
            load_res = 1'b1;
          end
        end
      end
      MD_FINISH: begin
        state_d = MD_IDLE;
      end
      default: begin
        state_d = MD_IDLE;
      end
    endcase
  end

  // Control state, counter and result register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q          <= MD_IDLE;
      cnt_q            <= '0;
      multdiv_result_o <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (load_res) begin
        multdiv_result_o <= md_fixup(acc_final, is_div_q, op_q, sign_a_q, sign_b_q, b_zero_q);
      end
    end
  end

  // Datapath registers: operand capture at launch, then one step per CALC cycle
  always_ff @(posedge clk) begin
    if (load_op) begin
      is_div_q <= div_en_i;
      op_q     <= operator_i;
      sign_a_q <= sign_a;
      sign_b_q <= sign_b;
      b_zero_q <= (op_b_i == 32'd0);
      addend_q <= div_en_i ? b_mag : a_mag;
      acc_q    <= {33'd0, (div_en_i ? a_mag : b_mag)};
`ifdef ZERORISCY_MULT_EARLY_EXIT_EN
      mplier_q <= b_mag;
`endif
    end else if (step_en) begin
      acc_q    <= acc_step;
`ifdef ZERORISCY_MULT_EARLY_EXIT_EN
      mplier_q <= mplier_q >> 1;
`endif
    end
  end

  assign ready_o = (state_q == MD_FINISH);

endmodule

// File: tb/tb_zeroriscy_multdiv_iter.sv
// Self-checking bench for zeroriscy_multdiv_iter: directed boundary cases
// plus random operations against a 64-bit arithmetic reference model.
module tb_zeroriscy_multdiv_iter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mult_en_i, div_en_i;
  logic [1:0]  operator_i, signed_mode_i;
  logic [31:0] op_a_i, op_b_i;
  logic        ready_o;
  logic [31:0] multdiv_result_o;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] last_res;
  logic        saw_ready;

  always #5 clk = ~clk;

  zeroriscy_multdiv_iter dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .mult_en_i        (mult_en_i),
    .div_en_i         (div_en_i),
    .operator_i       (operator_i),
    .signed_mode_i    (signed_mode_i),
    .op_a_i           (op_a_i),
    .op_b_i           (op_b_i),
    .ready_o          (ready_o),
    .multdiv_result_o (multdiv_result_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // RV32M semantics via 64-bit signed arithmetic
  function automatic logic [31:0] ref_md(input logic [1:0] op, input logic [1:0] mode,
                                         input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, r;
    sa = mode[0] ? longint'($signed(a)) : longint'({32'd0, a});
    sb = mode[1] ? longint'($signed(b)) : longint'({32'd0, b});
    r  = sa * sb;
    if (op == 2'd0) return r[31:0];
    if (op == 2'd1) return r[63:32];
    if (b == 32'd0) return (op == 2'd2) ? 32'hFFFF_FFFF : a;
    if (op == 2'd2) r = sa / sb;
    else            r = sa % sb;
    return r[31:0];
  endfunction

  // Cycle index (launch = 0) at which ready_o is expected
  function automatic int exp_lat(input logic [1:0] op, input logic [1:0] mode, input logic [31:0] b);
`ifdef ZERORISCY_MULT_EARLY_EXIT_EN
    logic [31:0] m;
    int          n;
    if (op < 2'd2) begin
      m = (mode[1] && b[31]) ? (32'd0 - b) : b;
      n = 0;
      for (int i = 0; i < 32; i++) if (m[i]) n = i + 1;
      return 1 + ((n < 1) ? 1 : n);
    end
`endif
    return 33;
  endfunction

  task automatic do_op(input logic [1:0] op, input logic [1:0] mode,
                       input logic [31:0] a, input logic [31:0] b, input string tag);
    logic [31:0] exp_res;
    int          exp_c, cyc;
    exp_res = ref_md(op, mode, a, b);
    exp_c   = exp_lat(op, mode, b);
    @(negedge clk);
    check({tag, "_idle_rdy"}, {31'd0, ready_o}, 32'd0);
    mult_en_i     = ~op[1];
    div_en_i      = op[1];
    operator_i    = op;
    signed_mode_i = mode;
    op_a_i        = a;
    op_b_i        = b;
    @(posedge clk);
    #1;
    op_a_i = $urandom;
    op_b_i = $urandom;
    cyc = 1;
    @(negedge clk);
    while (ready_o !== 1'b1 && cyc < 60) begin
      @(negedge clk);
      cyc++;
    end
    mult_en_i = 1'b0;
    div_en_i  = 1'b0;
    check({tag, "_lat"}, 32'(cyc), 32'(exp_c));
    check({tag, "_res"}, multdiv_result_o, exp_res);
    last_res = exp_res;
  endtask

  initial begin
    logic [1:0]  op, mode;
    logic [31:0] a, b;
    rst_n = 1'b0; mult_en_i = 1'b0; div_en_i = 1'b0;
    operator_i = 2'd0; signed_mode_i = 2'd0; op_a_i = '0; op_b_i = '0;
    last_res = '0;
    repeat (3) @(negedge clk);
    check("reset_ready", {31'd0, ready_o}, 32'd0);
    check("reset_result", multdiv_result_o, 32'd0);
    rst_n = 1'b1;

    // Directed cases
    do_op(2'd0, 2'b11, 32'd7, 32'hFFFF_FFFD, "mull_7_m3");
    do_op(2'd1, 2'b11, 32'h8000_0000, 32'h8000_0000, "mulh_ss");
    do_op(2'd1, 2'b00, 32'h8000_0000, 32'h8000_0000, "mulhu");
    do_op(2'd1, 2'b01, 32'h8000_0000, 32'h8000_0000, "mulhsu");
    do_op(2'd2, 2'b11, 32'hFFFF_FFFB, 32'd0, "div_by0");
    do_op(2'd3, 2'b11, 32'hFFFF_FFFB, 32'd0, "rem_by0");
    do_op(2'd2, 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    do_op(2'd3, 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, "rem_ovf");
    do_op(2'd0, 2'b11, 32'd123, 32'd1, "mull_b1");
    do_op(2'd0, 2'b00, 32'd5, 32'h8000_0000, "mull_bmsb");

    // Flush: divide dropped at cycle 10, new multiply at cycle 12
    @(negedge clk);
    div_en_i = 1'b1; mult_en_i = 1'b0; operator_i = 2'd2; signed_mode_i = 2'b11;
    op_a_i = 32'd100; op_b_i = 32'd7;
    @(posedge clk);
    saw_ready = 1'b0;
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      if (ready_o !== 1'b0) saw_ready = 1'b1;
      if (c == 10) div_en_i = 1'b0;
    end
    check("flush_no_ready", {31'd0, saw_ready}, 32'd0);
    check("flush_hold", multdiv_result_o, last_res);
    do_op(2'd0, 2'b11, 32'd3, 32'd4, "flush_mull");

    // Reset in the middle of a calculation
    @(negedge clk);
    mult_en_i = 1'b1; operator_i = 2'd0; signed_mode_i = 2'b11;
    op_a_i = 32'd5; op_b_i = 32'hFFFF_FFFF;
    @(posedge clk);
    repeat (5) @(negedge clk);
    rst_n = 1'b0; mult_en_i = 1'b0;
    @(negedge clk);
    check("midrst_ready", {31'd0, ready_o}, 32'd0);
    check("midrst_result", multdiv_result_o, 32'd0);
    rst_n = 1'b1;
    do_op(2'd2, 2'b00, 32'd1000, 32'd7, "after_rst");

    // Random operations
    for (int i = 0; i < 30; i++) begin
      op   = 2'($urandom_range(0, 3));
      mode = op[1] ? (($urandom_range(0, 1) == 1) ? 2'b11 : 2'b00) : 2'($urandom_range(0, 3));
      a    = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : 32'($urandom);
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 15));
        2:       b = 32'hFFFF_FFFF;
        3:       b = 32'h8000_0000;
        default: b = 32'($urandom);
      endcase
      do_op(op, mode, a, b, $sformatf("rnd%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/zeroriscy_multdiv_iter.md
# zeroriscy_multdiv_iter

Area-optimised iterative multiply/divide unit answering the EX stage's RV32M request handshake (`mult_en_i`/`div_en_i` in, `ready_o`/`multdiv_result_o` out). It is a drop-in alternative to the single-cycle-multiply unit for small configurations. It uses one 33-bit add/subtract datapath, shared by radix-2 shift-add multiply and restoring divide. EX muxes `ready_o` into `ex_ready_o` and `multdiv_result_o` into the regfile write data.

## Interface
- No parameters.
- `clk`  in  1  core clock
- `rst_n`  in  1  synchronous active-low reset, sampled on rising `clk`
- `mult_en_i`  in  1  multiply request; held by ID until `ready_o`
- `div_en_i`  in  1  divide request; held by ID until `ready_o`
- `operator_i`  in  2  MD_OP_MULL=0, MD_OP_MULH=1, MD_OP_DIV=2, MD_OP_REM=3
- `signed_mode_i`  in  2  bit0: op_a signed, bit1: op_b signed
- `op_a_i`  in  32  multiplicand / dividend
- `op_b_i`  in  32  multiplier / divisor
- `ready_o`  out  1  result valid this cycle (one-cycle pulse)
- `multdiv_result_o`  out  32  result, registered

## Operation
- FSM states: MD_IDLE, MD_CALC, MD_FINISH.
- MD_IDLE:
  - `mult_en_i|div_en_i` latches operands, operator and sign mode.
  - Operands are converted to magnitudes; sign flags are kept.
  - Iteration counter loads 31. Next state MD_CALC.
- MD_CALC, multiply: if multiplier bit0 is set, add the multiplicand into the upper 33 bits of the 65-bit accumulator; then shift right.
- MD_CALC, divide: shift the partial remainder left by one, trial-subtract the divisor, and shift the quotient bit in.
- MD_CALC ends when the counter reaches 0 (see Configuration). Next state MD_FINISH.
- MD_FINISH: `ready_o`=1 and the result register is valid. Next state MD_IDLE.
- Sign fix-up (the result register is loaded on the CALC→FINISH transition):
  - MULL: low 32 bits, negated if the operand signs differ.
  - MULH: high 32 bits of the 64-bit product, negated if the signs differ. Mode 11=MULH, 01=MULHSU, 00=MULHU.
  - DIV: quotient negated if the signs differ and the divisor is ≠0.
  - REM: remainder takes the dividend's sign.
- Boundary rules:
  - Divide by zero: DIV=0xFFFFFFFF, REM=op_a. No trap.
  - Overflow 0x80000000 / -1 (signed): DIV=0x80000000, REM=0.
  - Magnitude of 0x80000000 is 0x80000000 unsigned. This is handled by the 33-bit datapath.
  - Request dropped during MD_CALC (flush): return to MD_IDLE next cycle, no `ready_o`, result register unchanged.
  - Operand changes after the launch cycle are ignored.
  - `mult_en_i` and `div_en_i` both high: divide takes priority (ID never issues this).

## Timing
- Reset: state MD_IDLE, `ready_o`=0, `multdiv_result_o`=0, counter=0.
- Launch at cycle 0 (request seen in MD_IDLE). MD_CALC runs cycles 1..32. `ready_o`=1 at cycle 33 (fixed latency 34 cycles including launch).
- `ready_o` is decoded from state only; no combinational path from inputs.
- Back-to-back: the next request is accepted in the MD_IDLE cycle following MD_FINISH. No bubble beyond this.
- `ready_o` is never asserted in MD_IDLE or MD_CALC.

## Configuration
- `ZERORISCY_MULT_EARLY_EXIT_EN` defined:
  - Multiply leaves MD_CALC once the remaining shifted multiplier is zero, with a minimum of one MD_CALC cycle.
  - The accumulator is aligned by the remaining shift count before fix-up.
  - Multiply latency = 2 + max(1, msb_index(|b|)+1) cycles.
  - Divide is unchanged.
- Undefined: all operations use the fixed 32-cycle MD_CALC.

## Structure
- `zeroriscy_defines` additions: `md_fsm_e` enum, and MD_OP_* constants (reused if already present).
- Natural sub-module: `zeroriscy_md_addsub`. It is the 33-bit add/subtract with carry-out, shared by both operations; the FSM selects add (multiply) or subtract (divide).
- Everything else stays in `zeroriscy_multdiv_iter`.

## Test plan
- MULL, a=7, b=-3, mode 11: `ready_o` at cycle 33, result 0xFFFFFFEB.
- MULH, a=0x80000000, b=0x80000000: mode 11 gives 0x40000000; mode 00 gives 0x40000000; mode 01 gives 0xC0000000.
- DIV/REM by zero, a=-5: DIV 0xFFFFFFFF, REM 0xFFFFFFFB. DIV 0x80000000 by -1: 0x80000000, REM 0.
- Flush: DIV launched, `div_en_i` dropped at cycle 10. No `ready_o` ever; back in MD_IDLE at cycle 11. A new MULL 3×4 launched at cycle 12 gives 12 at cycle 45.
- Reset asserted mid-MD_CALC: next cycle MD_IDLE, `ready_o`=0, result 0.
- Early exit enabled, MULL b=1: `ready_o` at cycle 2. With b=0x80000000: `ready_o` at cycle 33.
